vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the 640x480@60 VGA raster for the game: pixel enable, hCount/vCount, bright, sync pulses and pipelined colour output.
- Is the driving end of the hCount/vCount/bright/rgb interface that game-logic blocks consume. Those blocks return a combinational rgb_in computed from the counts.
- Also generates the per-frame game tick and the slow game clock that step the game state machine.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hSync low width in pixels.
- H_START, 144, first visible hCount.
- H_END, 784, first non-visible hCount after the active region.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines.
- V_START, 35, first visible vCount.
- V_END, 515, first non-visible vCount after the active region.
- FRAMES_PER_TICK, 1, frames between frame_tick pulses; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rgb_in  in  12  colour from game logic for the current hCount/vCount.
- pix_en  out  1  one-clk pixel strobe.
- hCount  out  10  horizontal counter, 0..H_TOTAL-1.
- vCount  out  10  vertical counter, 0..V_TOTAL-1.
- bright  out  1  active-video flag, aligned with hCount/vCount.
- hSync  out  1  active-low, pipelined to align with vga_rgb.
- vSync  out  1  active-low, pipelined to align with vga_rgb.
- vga_rgb  out  12  registered pixel colour to the DAC pins.
- frame_tick  out  1  one-clk pulse once per FRAMES_PER_TICK frames.
- game_clk  out  1  square wave toggling on each frame_tick.

Behaviour:
- Reset (async, immediate, including mid-frame) sets these values:
  - div_cnt, hCount, vCount, frame counter: 0.
  - bright: 0.
  - hSync, vSync: 1 (inactive).
  - vga_rgb: 0.
  - frame_tick, game_clk: 0.
- Pixel divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - pix_en = (div_cnt == CLK_DIV-1), combinational from the register.
  - With CLK_DIV=1, pix_en is constantly 1 after reset.
  - First pix_en occurs in the CLK_DIV-th cycle after reset release.
- Raster counters advance only on clk edges where pix_en=1:
  - hCount == H_TOTAL-1: hCount <- 0, and vCount increments (vCount == V_TOTAL-1 -> 0).
  - Otherwise: hCount <- hCount+1.
  - Counters never exceed TOTAL-1; there is no other wrap path.
- bright = (H_START <= hCount < H_END) && (V_START <= vCount < V_END).
  - It is decoded combinationally from the count registers so game logic sees it aligned with hCount/vCount.
  - Visible area is (144,35)..(783,514).
- Output pipeline stage, updated only on pix_en:
  - vga_rgb <- bright ? rgb_in : 0.
  - hSync <- ~(hCount < H_SYNC).
  - vSync <- ~(vCount < V_SYNC).
  - Net result: colour and syncs are co-aligned, one pixel after the counts.
  - Between pix_en strobes all three outputs hold.
- Frame tick:
  - On a pix_en edge where hCount==H_TOTAL-1 and vCount==V_TOTAL-1 (frame wrap), the frame counter increments.
  - When the frame counter reaches FRAMES_PER_TICK-1 it wraps to 0, and frame_tick is registered high for exactly one clk. frame_tick is 0 otherwise.
  - game_clk toggles in the same cycle frame_tick is set, giving one rising edge per 2*FRAMES_PER_TICK frames.
  - First frame_tick (defaults) comes after 800*525*4 = 1,680,000 clks.
- rgb_in is treated as combinational from hCount/vCount. No handshake; it is sampled only on pix_en.
- Invalid parameter combinations (H_END > H_TOTAL, V_END > V_TOTAL, zero divisors) are rejected by elaboration-time assertions.

Decomposition:
- Package vga_timing_pkg: 640x480 timing localparams, colour constants (BLACK, RED, WHITE), 10-bit count width.
- Sub-module pixel_enable_div: div_cnt and pix_en, parameterised by CLK_DIV. Reusable for the seven-segment scan clock.
- Raster counters, decode, output pipeline and frame tick stay in vga_timing_gen.

Test Plan:
- Reset release, defaults -> pix_en first high in cycle 4, then every 4 clks; hCount 0->1 on that edge; hSync=vSync=1, vga_rgb=0 during reset.
- Run one line -> hCount wraps 799->0 with vCount 0->1; hSync low for exactly 96 pixels (384 clks), asserted one pixel after hCount=0.
- Run one frame -> vSync low for exactly 2 lines; bright high for exactly 640x480 = 307200 pix_en strobes; first bright at (144,35), last at (783,514).
- rgb_in held 12'hF00 constant -> vga_rgb = 12'hF00 only in the pixel after bright pixels, 0 elsewhere including (784,35) and (144,515).
- FRAMES_PER_TICK=2 -> frame_tick single-clk pulses 3,360,000 clks apart; game_clk toggles with each pulse.
- Assert rst mid-line at (400,200) -> all outputs immediately at reset values; after release the raster restarts at (0,0) and the first frame_tick arrives after a full 1,680,000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, count width and colour constants
package vga_timing_pkg;
    localparam int CW = 10;
    typedef logic [CW-1:0] count_t;
    localparam int H_TOTAL_640 = 800;
    localparam int H_SYNC_640 = 96;
    localparam int H_START_640 = 144;
    localparam int H_END_640 = 784;
    localparam int V_TOTAL_480 = 525;
    localparam int V_SYNC_480 = 2;
    localparam int V_START_480 = 35;
    localparam int V_END_480 = 515;
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] RED = 12'hF00;
    localparam logic [11:0] WHITE = 12'hFFF;
endpackage

// File: rtl/pixel_enable_div.sv
// pixel_enable_div: one-clk strobe every CLK_DIV system clocks
module pixel_enable_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] div_cnt;
    assign pix_en = div_cnt == LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) div_cnt <= '0;
        else div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/colour pipeline and game frame tick
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = H_TOTAL_640,
    parameter int H_SYNC = H_SYNC_640,
    parameter int H_START = H_START_640,
    parameter int H_END = H_END_640,
    parameter int V_TOTAL = V_TOTAL_480,
    parameter int V_SYNC = V_SYNC_480,
    parameter int V_START = V_START_480,
    parameter int V_END = V_END_480,
    parameter int FRAMES_PER_TICK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] vga_rgb,
    output logic        frame_tick,
    output logic        game_clk
);
    if (CLK_DIV < 1 || FRAMES_PER_TICK < 1 || H_END > H_TOTAL || V_END > V_TOTAL ||
        H_TOTAL < 1 || V_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters");
    end

    localparam count_t H_LAST = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST = count_t'(V_TOTAL - 1);
    localparam int FW = FRAMES_PER_TICK > 1 ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_TICK - 1);

    logic h_last, v_last, frame_wrap, frame_last;
    logic [FW-1:0] frame_cnt;

    pixel_enable_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en)
    );

    assign h_last = hCount == H_LAST;
    assign v_last = vCount == V_LAST;
    assign frame_wrap = pix_en && h_last && v_last;
    assign frame_last = frame_cnt == F_LAST;
    // decoded from the count registers so game logic sees it in step with the counts
    assign bright = hCount >= count_t'(H_START) && hCount < count_t'(H_END) &&
                    vCount >= count_t'(V_START) && vCount < count_t'(V_END);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pix_en) begin
            hCount <= h_last ? '0 : hCount + 1'b1;
            if (h_last) vCount <= v_last ? '0 : vCount + 1'b1;
        end

    // one pixel of latency keeps syncs co-aligned with the registered colour
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vga_rgb <= BLACK;
            hSync <= 1'b1;
            vSync <= 1'b1;
        end else if (pix_en) begin
            vga_rgb <= bright ? rgb_in : BLACK;
            hSync <= hCount >= count_t'(H_SYNC);
            vSync <= vCount >= count_t'(V_SYNC);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            frame_cnt <= '0;
            frame_tick <= 1'b0;
            game_clk <= 1'b0;
        end else begin
            frame_tick <= frame_wrap && frame_last;
            if (frame_wrap) frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
            if (frame_wrap && frame_last) game_clk <= ~game_clk;
        end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a shrunken raster (20x10 lines, 4 clk/pixel, tick every 2 frames)
module tb_vga_timing_gen;
    localparam int CD = 4, HT = 20, HS = 3, HB = 5, HE = 17;
    localparam int VT = 10, VS = 2, VB = 3, VE = 8, FPT = 2;
    localparam int FRAME_CLKS = HT * VT * CD;

    logic clk = 0, rst = 1;
    logic [11:0] rgb_in = 12'hF00;
    logic pix_en, bright, hSync, vSync, frame_tick, game_clk;
    logic [9:0] hCount, vCount;
    logic [11:0] vga_rgb;
    int vectors = 0, miscompares = 0;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB), .H_END(HE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_END(VE), .FRAMES_PER_TICK(FPT)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_en(pix_en), .hCount(hCount),
        .vCount(vCount), .bright(bright), .hSync(hSync), .vSync(vSync),
        .vga_rgb(vga_rgb), .frame_tick(frame_tick), .game_clk(game_clk)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        vectors++;
        if ({hCount, vCount, bright, hSync, vSync, vga_rgb, frame_tick, game_clk, pix_en} !==
            {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: h=%0d v=%0d br=%b hs=%b vs=%b rgb=%h ft=%b gc=%b pe=%b (want 0 0 0 1 1 000 0 0 0)",
                     hCount, vCount, bright, hSync, vSync, vga_rgb, frame_tick, game_clk, pix_en);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pix_en !== (i % 4 == 3)) begin
                miscompares++;
                $display("FAIL pix_en_cycle%0d: got %b want %b", i + 1, pix_en, i % 4 == 3);
            end
            if (i == 4) begin
                vectors++;
                if (hCount !== 10'd1 || hSync !== 1'b0) begin
                    miscompares++;
                    $display("FAIL first_pixel_edge: h=%0d hs=%b want h=1 hs=0", hCount, hSync);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_line();
        int n, low;
        do_reset();
        n = 0;
        while (!(hCount == HT - 1 && pix_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (hCount !== 10'(HT - 1) || vCount !== 10'd0 || hSync !== 1'b1) begin
            miscompares++;
            $display("FAIL line_end: h=%0d v=%0d hs=%b want h=%0d v=0 hs=1", hCount, vCount, hSync, HT - 1);
        end
        @(negedge clk);
        vectors++;
        if (hCount !== 10'd0 || vCount !== 10'd1 || hSync !== 1'b1) begin
            miscompares++;
            $display("FAIL line_wrap: h=%0d v=%0d hs=%b want h=0 v=1 hs=1", hCount, vCount, hSync);
        end
        low = 0;
        for (int i = 0; i < HT * CD; i++) begin
            @(negedge clk);
            if (!hSync) low++;
        end
        vectors++;
        if (low != HS * CD) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d clks want %0d", low, HS * CD);
        end
    endtask

    task automatic test_frame();
        int vs_low, br_cnt, fh, fv, lh, lv, rgb_bad;
        logic prev_bright, seen;
        logic [11:0] at_17_3, at_18_3, at_6_8;
        rgb_in = 12'hF00;
        do_reset();
        vs_low = 0; br_cnt = 0; rgb_bad = 0; seen = 0; prev_bright = 0;
        fh = -1; fv = -1; lh = -1; lv = -1;
        at_17_3 = 12'hxxx; at_18_3 = 12'hxxx; at_6_8 = 12'hxxx;
        for (int j = 0; j < FRAME_CLKS; j++) begin
            if (!vSync) vs_low++;
            if (j % CD == 0 && j > 0 && vga_rgb !== (prev_bright ? 12'hF00 : 12'h000)) rgb_bad++;
            if (j % CD == 0 && hCount == 17 && vCount == 3) at_17_3 = vga_rgb;
            if (j % CD == 0 && hCount == 18 && vCount == 3) at_18_3 = vga_rgb;
            if (j % CD == 0 && hCount == 6 && vCount == 8) at_6_8 = vga_rgb;
            if (pix_en) begin
                prev_bright = bright;
                if (bright) begin
                    br_cnt++;
                    if (!seen) begin fh = hCount; fv = vCount; seen = 1; end
                    lh = hCount; lv = vCount;
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (vs_low != VS * HT * CD) begin
            miscompares++;
            $display("FAIL vsync_width: got %0d clks want %0d", vs_low, VS * HT * CD);
        end
        vectors++;
        if (br_cnt != (HE - HB) * (VE - VB)) begin
            miscompares++;
            $display("FAIL bright_count: got %0d want %0d", br_cnt, (HE - HB) * (VE - VB));
        end
        vectors++;
        if (fh != HB || fv != VB || lh != HE - 1 || lv != VE - 1) begin
            miscompares++;
            $display("FAIL bright_corners: first (%0d,%0d) last (%0d,%0d) want (5,3) (16,7)", fh, fv, lh, lv);
        end
        vectors++;
        if (rgb_bad != 0) begin
            miscompares++;
            $display("FAIL rgb_pipeline: %0d bad pixels want 0", rgb_bad);
        end
        vectors++;
        if (at_17_3 !== 12'hF00 || at_18_3 !== 12'h000 || at_6_8 !== 12'h000) begin
            miscompares++;
            $display("FAIL rgb_edges: got %h %h %h want f00 000 000", at_17_3, at_18_3, at_6_8);
        end
    endtask

    task automatic test_tick();
        int t1, t2, highs;
        do_reset();
        t1 = -1; t2 = -1; highs = 0;
        for (int j = 0; j <= 2 * FPT * FRAME_CLKS + 50; j++) begin
            if (frame_tick) begin
                highs++;
                if (t1 < 0) t1 = j; else if (t2 < 0) t2 = j;
            end
            if (j == FPT * FRAME_CLKS - 1 || j == FPT * FRAME_CLKS || j == 2 * FPT * FRAME_CLKS) begin
                vectors++;
                if (game_clk !== (j == FPT * FRAME_CLKS)) begin
                    miscompares++;
                    $display("FAIL game_clk_at_%0d: got %b want %b", j, game_clk, j == FPT * FRAME_CLKS);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (t1 != FPT * FRAME_CLKS || t2 != 2 * FPT * FRAME_CLKS || highs != 2) begin
            miscompares++;
            $display("FAIL frame_tick_timing: at %0d,%0d (%0d high clks) want %0d,%0d (2)",
                     t1, t2, highs, FPT * FRAME_CLKS, 2 * FPT * FRAME_CLKS);
        end
    endtask

    task automatic test_mid_reset();
        int n, t1;
        do_reset();
        repeat (FPT * FRAME_CLKS + 100) @(negedge clk);
        n = 0;
        while (!(hCount == 8 && vCount == 4) && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (hCount !== 10'd8 || vCount !== 10'd4 || game_clk !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_setup: h=%0d v=%0d gc=%b want 8 4 1", hCount, vCount, game_clk);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if ({hCount, vCount, bright, hSync, vSync, vga_rgb, frame_tick, game_clk} !==
            {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset_values: h=%0d v=%0d br=%b hs=%b vs=%b rgb=%h ft=%b gc=%b",
                     hCount, vCount, bright, hSync, vSync, vga_rgb, frame_tick, game_clk);
        end
        @(negedge clk);
        rst = 0;
        t1 = -1;
        for (int j = 0; j <= FPT * FRAME_CLKS + 50 && t1 < 0; j++) begin
            if (frame_tick) t1 = j;
            @(negedge clk);
        end
        vectors++;
        if (t1 != FPT * FRAME_CLKS) begin
            miscompares++;
            $display("FAIL tick_after_reset: at %0d want %0d", t1, FPT * FRAME_CLKS);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_tick();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
